// File: rtl/hc_stream_requestor.sv
// Job sequencer: streams NUM_LINES cache lines from src_base through a fixed-latency kernel,
// writes results to dst_base, then posts a completion line to dsm_base. Optional macro: HC_STREAM_PERF_EN.
module hc_stream_requestor #(
    parameter int ADDR_W       = 42,
    parameter int DATA_W       = 512,
    parameter int MDATA_W      = 16,
    parameter int LINES_W      = 32,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    input  logic [ADDR_W-1:0]  dsm_base,
    input  logic [LINES_W-1:0] num_lines,
    output logic               busy,
    output logic               done,
    output logic               rd_req_valid,
    output logic [ADDR_W-1:0]  rd_req_addr,
    output logic [MDATA_W-1:0] rd_req_mdata,
    input  logic               rd_almfull,
    input  logic               rd_rsp_valid,
    input  logic [DATA_W-1:0]  rd_rsp_data,
    output logic               acc_out_valid,
    output logic [DATA_W-1:0]  acc_out_data,
    input  logic               acc_in_valid,
    input  logic [DATA_W-1:0]  acc_in_data,
    output logic               wr_req_valid,
    output logic [ADDR_W-1:0]  wr_req_addr,
    output logic [MDATA_W-1:0] wr_req_mdata,
    output logic [DATA_W-1:0]  wr_req_data,
    input  logic               wr_almfull,
    input  logic               wr_rsp_valid
);

    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DSM,
        DONE_ST
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  src_q, dst_q, dsm_q;
    logic [LINES_W-1:0] num_q, rd_idx_q, wr_idx_q, ack_cnt_q;
    logic [CNT_W-1:0]   inflight_q;
    logic               dsm_sent_q;

    logic [DATA_W-1:0]  fifo_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;

    logic               accept, rd_issue, wr_issue, dsm_issue, active;
    logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [ADDR_W-1:0]  rd_addr;
    logic [MDATA_W-1:0] rd_mdata;
    logic [DATA_W-1:0]  dsm_data;

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == MAX_CNT);
    // Results outside a job (IDLE, DONE_ST, or after a mid-job reset) never touch the FIFO.
    assign fifo_push  = active && acc_in_valid;
    assign fifo_pop   = wr_issue;

    // The first read of a job is issued straight from the launch inputs so it leaves one cycle after start.
    assign rd_addr  = (state_q == IDLE) ? src_base : src_q + ADDR_W'(rd_idx_q);
    assign rd_mdata = (state_q == IDLE) ? '0 : MDATA_W'(rd_idx_q);

    // NOTE: every output of a combinational block gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rd_issue  = 1'b0;
        wr_issue  = 1'b0;
        dsm_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    rd_issue = (num_lines != '0) && !rd_almfull;
                    state_d  = (num_lines == '0) ? DSM : RUN;
                end
            end
            RUN: begin
                rd_issue = !rd_almfull && (inflight_q < MAX_CNT) && (rd_idx_q < num_q);
                wr_issue = !fifo_empty && !wr_almfull;
                if (rd_idx_q == num_q) state_d = DRAIN;
            end
            DRAIN: begin
                wr_issue = !fifo_empty && !wr_almfull;
                if ((wr_idx_q == num_q) && (ack_cnt_q == num_q)) state_d = DSM;
            end
            DSM: begin
                dsm_issue = !dsm_sent_q && !wr_almfull;
                if (dsm_sent_q && wr_rsp_valid) state_d = DONE_ST;
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            dsm_q      <= '0;
            num_q      <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            ack_cnt_q  <= '0;
            inflight_q <= '0;
            dsm_sent_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q      <= src_base;
                dst_q      <= dst_base;
                dsm_q      <= dsm_base;
                num_q      <= num_lines;
                rd_idx_q   <= rd_issue ? LINES_W'(1) : '0;
                wr_idx_q   <= '0;
                ack_cnt_q  <= '0;
                inflight_q <= rd_issue ? CNT_W'(1) : '0;
                dsm_sent_q <= 1'b0;
            end else begin
                if (rd_issue)                rd_idx_q  <= rd_idx_q + 1'b1;
                if (wr_issue)                wr_idx_q  <= wr_idx_q + 1'b1;
                if (active && wr_rsp_valid)  ack_cnt_q <= ack_cnt_q + 1'b1;
                if (dsm_issue)               dsm_sent_q <= 1'b1;
                // Credits cover the whole read-to-write span, which bounds FIFO occupancy.
                case ({rd_issue, wr_issue})
                    2'b10:   inflight_q <= inflight_q + 1'b1;
                    2'b01:   inflight_q <= inflight_q - 1'b1;
                    default: inflight_q <= inflight_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else if (accept) begin
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            if (fifo_push) fifo_wr_ptr_q <= fifo_wr_ptr_q + 1'b1;
            if (fifo_pop)  fifo_rd_ptr_q <= fifo_rd_ptr_q + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr_q] <= acc_in_data;
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(fifo_push && fifo_full && !fifo_pop));

`ifdef HC_STREAM_PERF_EN
    logic [63:0] perf_cyc_q, perf_rd_stall_q, perf_wr_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cyc_q      <= '0;
            perf_rd_stall_q <= '0;
            perf_wr_stall_q <= '0;
        end else if (accept) begin
            perf_cyc_q      <= '0;
            perf_rd_stall_q <= '0;
            perf_wr_stall_q <= '0;
        end else begin
            if ((state_q != IDLE) && (state_q != DONE_ST) && !dsm_sent_q)
                perf_cyc_q <= perf_cyc_q + 1'b1;
            if ((state_q == RUN) && (rd_idx_q < num_q) && (rd_almfull || (inflight_q >= MAX_CNT)))
                perf_rd_stall_q <= perf_rd_stall_q + 1'b1;
            if (active && !fifo_empty && wr_almfull)
                perf_wr_stall_q <= perf_wr_stall_q + 1'b1;
        end
    end
`endif

    always_comb begin
        dsm_data        = '0;
        dsm_data[0]     = 1'b1;
        dsm_data[63:32] = 32'(wr_idx_q);
`ifdef HC_STREAM_PERF_EN
        dsm_data[127:64]  = perf_cyc_q;
        dsm_data[191:128] = perf_rd_stall_q;
        dsm_data[255:192] = perf_wr_stall_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_req_valid  <= 1'b0;
            rd_req_addr   <= '0;
            rd_req_mdata  <= '0;
            acc_out_valid <= 1'b0;
            acc_out_data  <= '0;
            wr_req_valid  <= 1'b0;
            wr_req_addr   <= '0;
            wr_req_mdata  <= '0;
            wr_req_data   <= '0;
        end else begin
            if (accept) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (state_q == DONE_ST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end

            rd_req_valid <= rd_issue;
            if (rd_issue) begin
                rd_req_addr  <= rd_addr;
                rd_req_mdata <= rd_mdata;
            end

            acc_out_valid <= active && rd_rsp_valid;
            if (active && rd_rsp_valid) acc_out_data <= rd_rsp_data;

            wr_req_valid <= wr_issue || dsm_issue;
            if (wr_issue) begin
                wr_req_addr  <= dst_q + ADDR_W'(wr_idx_q);
                wr_req_mdata <= MDATA_W'(wr_idx_q);
                wr_req_data  <= fifo_mem[fifo_rd_ptr_q];
            end else if (dsm_issue) begin
                wr_req_addr  <= dsm_q;
                wr_req_mdata <= '1;
                wr_req_data  <= dsm_data;
            end
        end
    end

endmodule

// File: tb/tb_hc_stream_requestor.sv
// Self-checking bench for hc_stream_requestor: memory/kernel/ack responders plus a job-level
// model of the expected read, kernel and write sequences. Honours HC_STREAM_PERF_EN.
module tb_hc_stream_requestor;

    localparam int ADDR_W  = 42;
    localparam int DATA_W  = 512;
    localparam int MDATA_W = 16;
    localparam int LINES_W = 32;
    localparam int MAX_INF = 64;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic [ADDR_W-1:0]  src_base, dst_base, dsm_base;
    logic [LINES_W-1:0] num_lines;
    logic               busy, done;
    logic               rd_req_valid;
    logic [ADDR_W-1:0]  rd_req_addr;
    logic [MDATA_W-1:0] rd_req_mdata;
    logic               rd_almfull;
    logic               rd_rsp_valid;
    logic [DATA_W-1:0]  rd_rsp_data;
    logic               acc_out_valid;
    logic [DATA_W-1:0]  acc_out_data;
    logic               acc_in_valid;
    logic [DATA_W-1:0]  acc_in_data;
    logic               wr_req_valid;
    logic [ADDR_W-1:0]  wr_req_addr;
    logic [MDATA_W-1:0] wr_req_mdata;
    logic [DATA_W-1:0]  wr_req_data;
    logic               wr_almfull;
    logic               wr_rsp_valid;

    hc_stream_requestor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(MDATA_W),
        .LINES_W(LINES_W), .MAX_INFLIGHT(MAX_INF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .dsm_base(dsm_base), .num_lines(num_lines),
        .busy(busy), .done(done),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
        .rd_almfull(rd_almfull), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .acc_out_valid(acc_out_valid), .acc_out_data(acc_out_data),
        .acc_in_valid(acc_in_valid), .acc_in_data(acc_in_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata),
        .wr_req_data(wr_req_data), .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [MDATA_W-1:0] mdata;
    } rd_exp_t;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [MDATA_W-1:0] mdata;
        logic [DATA_W-1:0]  data;
        bit                 is_dsm;
        int                 lines;
    } wr_exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } timed_t;

    rd_exp_t           exp_rd[$];
    logic [DATA_W-1:0] exp_acc[$];
    wr_exp_t           exp_wr[$];

    logic [ADDR_W-1:0] seen_rd[$];
    logic [ADDR_W-1:0] seen_wr[$];
    logic [DATA_W-1:0] dsm_seen;
    int rd_job = 0, wr_job = 0, dsm_cnt = 0;
    int acks_driven = 0, ack_base = 0, stray_cnt = 0;
    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] line_data(input logic [ADDR_W-1:0] a);
        return {8{22'h2A5A5, a}};
    endfunction

    function automatic logic [DATA_W-1:0] kern(input logic [DATA_W-1:0] x);
        return ~x;
    endfunction

    // Environment: in-order memory (latency 4), kernel (latency 3), write acks (latency 3).
    initial begin
        timed_t rq[$], kq[$];
        int aq[$];
        int cyc = 0;
        timed_t t;
        rd_rsp_valid = 1'b0; rd_rsp_data = '0;
        acc_in_valid = 1'b0; acc_in_data = '0;
        wr_rsp_valid = 1'b0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (reset_n && rd_req_valid)  begin t.data = line_data(rd_req_addr); t.due = cyc + 3; rq.push_back(t); end
            if (reset_n && acc_out_valid) begin t.data = kern(acc_out_data);     t.due = cyc + 2; kq.push_back(t); end
            if (reset_n && wr_req_valid)  aq.push_back(cyc + 2);
            rd_rsp_valid = 1'b0;
            acc_in_valid = 1'b0;
            wr_rsp_valid = 1'b0;
            if (stray_cnt > 0) begin
                stray_cnt--;
                rd_rsp_valid = 1'b1; rd_rsp_data = {16{32'hDEADBEEF}};
                acc_in_valid = 1'b1; acc_in_data = {16{32'hBADC0FFE}};
                wr_rsp_valid = 1'b1;
            end else begin
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    rd_rsp_valid = 1'b1; rd_rsp_data = rq[0].data; void'(rq.pop_front());
                end
                if (kq.size() > 0 && kq[0].due <= cyc) begin
                    acc_in_valid = 1'b1; acc_in_data = kq[0].data; void'(kq.pop_front());
                end
                if (aq.size() > 0 && aq[0] <= cyc) begin
                    wr_rsp_valid = 1'b1; acks_driven++; void'(aq.pop_front());
                end
            end
        end
    end

    // Compare process: every DUT transaction is matched against the job model.
    initial begin
        logic last_rd_af, last_wr_af;
        rd_exp_t re;
        wr_exp_t we;
        logic [DATA_W-1:0] ae;
        forever begin
            @(posedge clk);
            last_rd_af = rd_almfull;
            last_wr_af = wr_almfull;
            #1;
            if (!reset_n) begin
                rd_job = 0;
                wr_job = 0;
            end else begin
                if (rd_req_valid) begin
                    check("rd while almfull", last_rd_af, 0);
                    if (exp_rd.size() == 0) check("unexpected rd", 1, 0);
                    else begin
                        re = exp_rd.pop_front();
                        check("rd addr", rd_req_addr, re.addr);
                        check("rd mdata", rd_req_mdata, re.mdata);
                    end
                    seen_rd.push_back(rd_req_addr);
                    rd_job++;
                    check("inflight limit", (rd_job - wr_job) <= MAX_INF, 1);
                end
                if (acc_out_valid) begin
                    if (exp_acc.size() == 0) check("unexpected acc_out", 1, 0);
                    else begin
                        ae = exp_acc.pop_front();
                        check("acc_out data", acc_out_data, ae);
                    end
                end
                if (wr_req_valid) begin
                    check("wr while almfull", last_wr_af, 0);
                    if (exp_wr.size() == 0) check("unexpected wr", 1, 0);
                    else begin
                        we = exp_wr.pop_front();
                        check("wr addr", wr_req_addr, we.addr);
                        check("wr mdata", wr_req_mdata, we.mdata);
                        if (we.is_dsm) begin
                            check("dsm low word", wr_req_data[63:0], {32'(we.lines), 32'h1});
                            check("dsm upper zero", wr_req_data[DATA_W-1:256], '0);
`ifndef HC_STREAM_PERF_EN
                            check("dsm perf zero", wr_req_data[255:64], '0);
`endif
                            check("dsm after all acks", acks_driven - ack_base, we.lines);
                            dsm_seen = wr_req_data;
                            dsm_cnt++;
                        end else begin
                            check("wr data", wr_req_data, we.data);
                            seen_wr.push_back(wr_req_addr);
                            wr_job++;
                        end
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " rd_req_valid"}, rd_req_valid, 0);
        check({tag, " rd_req_addr"}, rd_req_addr, 0);
        check({tag, " rd_req_mdata"}, rd_req_mdata, 0);
        check({tag, " acc_out_valid"}, acc_out_valid, 0);
        check({tag, " acc_out_data"}, acc_out_data, 0);
        check({tag, " wr_req_valid"}, wr_req_valid, 0);
        check({tag, " wr_req_addr"}, wr_req_addr, 0);
        check({tag, " wr_req_mdata"}, wr_req_mdata, 0);
        check({tag, " wr_req_data"}, wr_req_data, 0);
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                             input logic [ADDR_W-1:0] dsm, input int n);
        rd_exp_t re;
        wr_exp_t we;
        logic [ADDR_W-1:0] a;
        exp_rd.delete(); exp_acc.delete(); exp_wr.delete();
        for (int i = 0; i < n; i++) begin
            a = src + ADDR_W'(i);
            re.addr = a; re.mdata = MDATA_W'(i);
            exp_rd.push_back(re);
            exp_acc.push_back(line_data(a));
            we.addr = dst + ADDR_W'(i); we.mdata = MDATA_W'(i);
            we.data = kern(line_data(a)); we.is_dsm = 1'b0; we.lines = 0;
            exp_wr.push_back(we);
        end
        we.addr = dsm; we.mdata = '1; we.data = '0; we.is_dsm = 1'b1; we.lines = n;
        exp_wr.push_back(we);
        seen_rd.delete(); seen_wr.delete();
        rd_job = 0; wr_job = 0; dsm_cnt = 0;
        ack_base = acks_driven;
        src_base = src; dst_base = dst; dsm_base = dsm; num_lines = LINES_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy at t+1", busy, 1);
        check("done cleared by start", done, 0);
        check("first rd at t+1", rd_req_valid, (n != 0) && !rd_almfull);
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy low"}, busy, 0);
        check({tag, " reads drained"}, exp_rd.size(), 0);
        check({tag, " kernel drained"}, exp_acc.size(), 0);
        check({tag, " writes drained"}, exp_wr.size(), 0);
        check({tag, " one dsm"}, dsm_cnt, 1);
    endtask

    task automatic wait_reads(input int target, input int limit, input string tag);
        int k = 0;
        while (rd_job < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, " reads reached"}, rd_job >= target, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0;
        src_base = '0; dst_base = '0; dsm_base = '0; num_lines = '0;
        rd_almfull = 1'b0; wr_almfull = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // T1: basic 4-line job
        start_job(42'h100, 42'h2000, 42'h3000, 4);
        wait_done(200, "T1");
        check("T1 rd count", seen_rd.size(), 4);
        check("T1 rd0", seen_rd[0], 42'h100);
        check("T1 rd3", seen_rd[3], 42'h103);
        check("T1 wr0", seen_wr[0], 42'h2000);
        check("T1 wr3", seen_wr[3], 42'h2003);
        check("T1 dsm lines", dsm_seen[63:32], 4);
        check("T1 dsm bit0", dsm_seen[0], 1);

        // T2: write back-pressure caps reads at the credit limit
        wr_almfull = 1'b1;
        start_job(42'h40000, 42'h80000, 42'h3000, 200);
        repeat (500) @(negedge clk);
        check("T2 reads capped", rd_job, 64);
        check("T2 no writes", wr_job, 0);
        wr_almfull = 1'b0;
        wait_done(3000, "T2");
        check("T2 wr count", seen_wr.size(), 200);
        check("T2 last wr", seen_wr[199], 42'h800C7);

        // T3: empty job
        start_job(42'h500, 42'h600, 42'h3040, 0);
        wait_done(100, "T3");
        check("T3 no reads", rd_job, 0);
        check("T3 no writes", wr_job, 0);
        check("T3 dsm lines", dsm_seen[63:32], 0);
        check("T3 dsm bit0", dsm_seen[0], 1);

        // T4: source address wraps
        start_job(42'h3FF_FFFF_FFFE, 42'h1000, 42'h3080, 4);
        wait_done(200, "T4");
        check("T4 rd0", seen_rd[0], 42'h3FF_FFFF_FFFE);
        check("T4 rd1", seen_rd[1], 42'h3FF_FFFF_FFFF);
        check("T4 rd2", seen_rd[2], 42'h0);
        check("T4 rd3", seen_rd[3], 42'h1);

        // T5: async reset mid-job, stray responses, then a clean job
        start_job(42'h10000, 42'h20000, 42'h30C0, 32);
        wait_reads(10, 200, "T5");
        #1;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("T5 async");
        exp_rd.delete(); exp_acc.delete(); exp_wr.delete();
        @(negedge clk);
        reset_n = 1'b1;
        stray_cnt = 3;
        repeat (40) @(negedge clk);
        check_outputs_zero("T5 after strays");
        start_job(42'h700, 42'h800, 42'h3100, 2);
        wait_done(100, "T5b");
        check("T5b wr count", seen_wr.size(), 2);
        check("T5b wr1", seen_wr[1], 42'h801);

        // T6: read back-pressure for 10 cycles
        start_job(42'h9000, 42'hA000, 42'h3140, 16);
        wait_reads(4, 100, "T6");
        rd_almfull = 1'b1;
        repeat (10) @(negedge clk);
        rd_almfull = 1'b0;
        wait_done(300, "T6");
`ifdef HC_STREAM_PERF_EN
        check("T6 rd stall count >= 10", dsm_seen[191:128] >= 64'd10, 1);
`else
        check("T6 perf field", dsm_seen[255:64], 0);
`endif
        check("T6 dsm lines", dsm_seen[63:32], 16);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
